alu: RTL and testbench



---
 rtl/alu.sv | 81 ++++++++
 tb/tb_alu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 4-bit ALU with arithmetic and logic modes.
// R, z, c and s are captured every clock edge, giving one cycle of latency.
module alu #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic [1:0]       Op,
    input  logic             l,
    output logic [WIDTH-1:0] R,
    output logic             z,
    output logic             c,
    output logic             s
);

    logic [WIDTH-1:0] r_d, r_q;
    logic             z_d, z_q;
    logic             c_d, c_q;
    logic             s_d, s_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   one_ext;

    assign cin_ext = {{WIDTH{1'b0}}, cin};
    assign one_ext = {{WIDTH{1'b0}}, 1'b1};

    // Arithmetic is done one bit wider so that bit WIDTH becomes the carry.
    always_comb begin
        sum = '0;
        unique case (Op)
            2'b00: sum = {1'b0, A} + cin_ext;
            2'b01: sum = {1'b0, ~A} + one_ext + cin_ext;
            2'b10: sum = {1'b0, A} + {1'b0, B} + cin_ext;
            2'b11: sum = {1'b0, ~B} + cin_ext;
            default: sum = '0;
        endcase
    end

    always_comb begin
        r_d = '0;
        c_d = 1'b0;
        if (l) begin
            unique case (Op)
                2'b00: r_d = A & B;
                2'b01: r_d = A | B;
                2'b10: r_d = A ^ B;
                2'b11: r_d = ~A;
                default: r_d = '0;
            endcase
        end else begin
            r_d = sum[WIDTH-1:0];
            c_d = sum[WIDTH];
        end
        s_d = r_d[WIDTH-1];
        z_d = (r_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
            z_q <= 1'b1;
            c_q <= 1'b0;
            s_q <= 1'b0;
        end else begin
            r_q <= r_d;
            z_q <= z_d;
            c_q <= c_d;
            s_q <= s_d;
        end
    end

    assign R = r_q;
    assign z = z_q;
    assign c = c_q;
    assign s = s_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed scenarios, reset behaviour and an exhaustive sweep.
// Compared values are packed as {1'b0, z, c, s, R[3:0]}.
module tb_alu;

    logic       clk;
    logic       reset;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic [1:0] Op;
    logic       l;
    logic [3:0] R;
    logic       z;
    logic       c;
    logic       s;

    int n_checks = 0;
    int n_errors = 0;

    alu #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .Op    (Op),
        .l     (l),
        .R     (R),
        .z     (z),
        .c     (c),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got zcsR=%b expected zcsR=%b", tag, got[6:0], exp[6:0]);
        end
    endtask

    function automatic logic [7:0] pack(input logic zz, input logic cc, input logic ss,
                                        input logic [3:0] rr);
        return {1'b0, zz, cc, ss, rr};
    endfunction

    // Reference computed with integer arithmetic.
    function automatic logic [7:0] model(input int lm, input int op, input int ci,
                                         input int a, input int b);
        int sum;
        int r;
        int cy;
        cy = 0;
        if (lm == 1) begin
            case (op)
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                default: r = 15 - a;
            endcase
        end else begin
            case (op)
                0: sum = a + ci;
                1: sum = (15 - a) + 1 + ci;
                2: sum = a + b + ci;
                default: sum = (15 - b) + ci;
            endcase
            r  = sum % 16;
            cy = (sum >= 16) ? 1 : 0;
        end
        return pack(r == 0, cy[0], r >= 8, r[3:0]);
    endfunction

    task automatic apply(input logic ll, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic ci);
        l = ll; Op = op; A = a; B = b; cin = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        A = 4'h0; B = 4'h0; cin = 1'b0; Op = 2'b00; l = 1'b0;
        #2;
        check("reset_state", pack(z, c, s, R), pack(1'b1, 1'b0, 1'b0, 4'b0000));
        @(negedge clk);
        reset = 1'b0;

        apply(1'b0, 2'b10, 4'b0111, 4'b0001, 1'b0);
        check("add_7_1", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b1, 4'b1000));
        apply(1'b0, 2'b01, 4'b0000, 4'b1010, 1'b0);
        check("neg_0", pack(z, c, s, R), pack(1'b1, 1'b1, 1'b0, 4'b0000));
        apply(1'b0, 2'b01, 4'b0011, 4'b1010, 1'b1);
        check("neg_3_cin", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b1, 4'b1110));
        apply(1'b0, 2'b11, 4'b0110, 4'b0101, 1'b1);
        check("notb_cin", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b1, 4'b1011));
        apply(1'b0, 2'b00, 4'b1111, 4'b0101, 1'b1);
        check("inc_wrap", pack(z, c, s, R), pack(1'b1, 1'b1, 1'b0, 4'b0000));
        apply(1'b0, 2'b10, 4'b1111, 4'b0001, 1'b0);
        check("add_wrap", pack(z, c, s, R), pack(1'b1, 1'b1, 1'b0, 4'b0000));

        apply(1'b1, 2'b00, 4'b1100, 4'b1010, 1'b1);
        check("and", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b1, 4'b1000));
        apply(1'b1, 2'b01, 4'b1100, 4'b1010, 1'b1);
        check("or", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b1, 4'b1110));
        apply(1'b1, 2'b10, 4'b1100, 4'b1010, 1'b1);
        check("xor", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b0, 4'b0110));
        apply(1'b1, 2'b11, 4'b1100, 4'b1010, 1'b1);
        check("not_a", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b0, 4'b0011));
        apply(1'b1, 2'b11, 4'b1111, 4'b1010, 1'b0);
        check("not_a_zero", pack(z, c, s, R), pack(1'b1, 1'b0, 1'b0, 4'b0000));

        // Asynchronous reset mid-cycle while R=1000, then a fresh load after release.
        apply(1'b0, 2'b10, 4'b0111, 4'b0001, 1'b0);
        check("pre_reset", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b1, 4'b1000));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", pack(z, c, s, R), pack(1'b1, 1'b0, 1'b0, 4'b0000));
        @(negedge clk);
        #1;
        check("reset_hold", pack(z, c, s, R), pack(1'b1, 1'b0, 1'b0, 4'b0000));
        reset = 1'b0;
        #1;
        check("post_release", pack(z, c, s, R), pack(1'b1, 1'b0, 1'b0, 4'b0000));
        apply(1'b0, 2'b10, 4'b0011, 4'b0010, 1'b1);
        check("first_load", pack(z, c, s, R), pack(1'b0, 1'b0, 1'b0, 4'b0110));

        for (int lm = 0; lm < 2; lm++) begin
            for (int op = 0; op < 4; op++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    for (int a = 0; a < 16; a++) begin
                        for (int b = 0; b < 16; b++) begin
                            apply(lm[0], op[1:0], a[3:0], b[3:0], ci[0]);
                            check($sformatf("sweep l=%0d op=%0d cin=%0d a=%0d b=%0d",
                                            lm, op, ci, a, b),
                                  pack(z, c, s, R), model(lm, op, ci, a, b));
                        end
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
